// File: rtl/si_tag_serializer_if.sv
// rtl/si_tag_serializer_if.sv - beat-in / tag-out stream bundle for si_tag_serializer
//
// Input side (s_axis_*): multi-lane beats of up to NUMBER_OF_WORDS tags.
//   s_axis_tvalid, s_axis_tready, s_axis_tagtime[N] (64b, 1/3 ps),
//   s_axis_channel[N] (6b signed), s_axis_tkeep[N] (lane present).
// Output side (m_axis_*): one tag per handshake.
//   m_axis_tvalid, m_axis_tready, m_axis_tagtime (64b), m_axis_channel (6b signed),
//   m_axis_lane (source lane), m_axis_tlast (last tag of its beat).
// Modport slave is the serializer's view; modport master is the surrounding logic's view.
interface si_tag_serializer_if #(
    parameter int NUMBER_OF_WORDS = 4
);
    localparam int LANE_W = (NUMBER_OF_WORDS > 1) ? $clog2(NUMBER_OF_WORDS) : 1;

    logic                              s_axis_tvalid;
    logic                              s_axis_tready;
    logic [NUMBER_OF_WORDS-1:0][63:0]  s_axis_tagtime;
    logic [NUMBER_OF_WORDS-1:0][5:0]   s_axis_channel;
    logic [NUMBER_OF_WORDS-1:0]        s_axis_tkeep;

    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic [63:0]                       m_axis_tagtime;
    logic signed [5:0]                 m_axis_channel;
    logic [LANE_W-1:0]                 m_axis_lane;
    logic                              m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_lane,
               m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tagtime, s_axis_channel, s_axis_tkeep, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tagtime, m_axis_channel, m_axis_lane,
               m_axis_tlast
    );
endinterface

// File: rtl/si_tag_serializer.sv
// rtl/si_tag_serializer.sv - serializes sparse multi-lane tag beats into one tag per cycle
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   channel_enable per-channel enable, only with SI_TAG_SERIALIZER_FILTER_EN defined
//                  (bit c-1 = +c, bit CHANNEL_COUNT+c-1 = -c)
//   bus            si_tag_serializer_if.slave: s_axis_* beats in, m_axis_* tags out
//   tag_count      number of emitted tags, wraps modulo 2^32
//
// Optional feature macro: SI_TAG_SERIALIZER_FILTER_EN (channel filter at load time).
module si_tag_serializer #(
    parameter int CHANNEL_COUNT   = 20,
    parameter int NUMBER_OF_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef SI_TAG_SERIALIZER_FILTER_EN
    input  logic [2*CHANNEL_COUNT-1:0] channel_enable,
`endif
    si_tag_serializer_if.slave         bus,
    output logic [31:0]                tag_count
);
    localparam int N      = NUMBER_OF_WORDS;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][63:0] time_q;
    logic [N-1:0][5:0]  chan_q;
    logic [N-1:0]       pending_q, pending_d;
    logic [31:0]        count_q;

    logic [LANE_W-1:0]  sel;
    logic               any_pending;
    logic               one_pending;
    logic               s_fire;
    logic               m_fire;
    logic [N-1:0]       load_mask;

    // Lowest pending lane is the oldest tag still held.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) sel = LANE_W'(i);
        end
    end

    assign any_pending = |pending_q;
    assign one_pending = any_pending && ((pending_q & (pending_q - N'(1))) == '0);

`ifdef SI_TAG_SERIALIZER_FILTER_EN
    logic [N-1:0] lane_en;

    // Match each lane's signed channel against every enable bit; an unmatched
    // code (0 or out of range) leaves the lane disabled.
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < N; i++) begin
            for (int c = 1; c <= CHANNEL_COUNT; c++) begin
                if (bus.s_axis_channel[i] == 6'(c))
                    lane_en[i] = channel_enable[c-1];
                if (bus.s_axis_channel[i] == 6'(-c))
                    lane_en[i] = channel_enable[CHANNEL_COUNT+c-1];
            end
        end
    end

    assign load_mask = bus.s_axis_tkeep & lane_en;
`else
    assign load_mask = bus.s_axis_tkeep;
`endif

    // Accept a new beat when empty, or when the final held tag leaves this cycle.
    assign bus.s_axis_tready = !any_pending || (one_pending && bus.m_axis_tready);
    assign s_fire            = bus.s_axis_tvalid && bus.s_axis_tready;
    assign m_fire            = any_pending && bus.m_axis_tready;

    assign bus.m_axis_tvalid  = any_pending;
    assign bus.m_axis_tagtime = any_pending ? time_q[sel] : 64'd0;
    assign bus.m_axis_channel = any_pending ? $signed(chan_q[sel]) : 6'sd0;
    assign bus.m_axis_lane    = any_pending ? sel : '0;
    assign bus.m_axis_tlast   = one_pending;
    assign tag_count          = count_q;

    // Load overrides the clear so back-to-back beats leave no bubble.
    always_comb begin
        pending_d = pending_q;
        if (m_fire) pending_d[sel] = 1'b0;
        if (s_fire) pending_d = load_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q    <= '0;
            chan_q    <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            if (s_fire) begin
                time_q <= bus.s_axis_tagtime;
                chan_q <= bus.s_axis_channel;
            end
            if (m_fire) count_q <= count_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_si_tag_serializer.sv
// tb/tb_si_tag_serializer.sv - directed self-checking bench for si_tag_serializer
module tb_si_tag_serializer;
    logic clk;
    logic rst_n;
    logic [31:0] tag_count;
    int n_cmp;
    int n_err;

    si_tag_serializer_if #(.NUMBER_OF_WORDS(4)) bus ();

`ifdef SI_TAG_SERIALIZER_FILTER_EN
    logic [39:0] channel_enable;
    si_tag_serializer #(.CHANNEL_COUNT(20), .NUMBER_OF_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .channel_enable(channel_enable), .bus(bus),
        .tag_count(tag_count));
`else
    si_tag_serializer #(.CHANNEL_COUNT(20), .NUMBER_OF_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .tag_count(tag_count));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {tvalid, tagtime, channel, lane, tlast}
    function automatic logic [73:0] out_vec();
        return {bus.m_axis_tvalid, bus.m_axis_tagtime, bus.m_axis_channel, bus.m_axis_lane,
                bus.m_axis_tlast};
    endfunction

    function automatic logic [73:0] exp_vec(logic v, logic [63:0] t, logic [5:0] c,
                                            logic [1:0] l, logic last);
        return {v, t, c, l, last};
    endfunction

    task automatic idle_inputs();
        bus.s_axis_tvalid  = 1'b0;
        bus.s_axis_tkeep   = 4'h0;
        bus.s_axis_tagtime = '0;
        bus.s_axis_channel = '0;
    endtask

    task automatic test_reset();
        logic [73:0] o;
        #2;
        o = out_vec();
        n_cmp++; if (o !== 74'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", o); end
        n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL reset_s_tready: got %b want 1", bus.s_axis_tready); end
        n_cmp++; if (tag_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", tag_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // Load a beat with lanes 1 and 2 held, then stall it.
        @(negedge clk);
        bus.m_axis_tready     = 1'b0;
        bus.s_axis_tvalid     = 1'b1;
        bus.s_axis_tkeep      = 4'b0110;
        bus.s_axis_tagtime[1] = 64'd11;
        bus.s_axis_tagtime[2] = 64'd12;
        bus.s_axis_channel[1] = 6'd4;
        bus.s_axis_channel[2] = 6'd6;
        @(negedge clk);
        idle_inputs();
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd11, 6'd4, 2'd1, 1'b0)) begin n_err++; $display("FAIL midbeat_hold: got %h want %h", o, exp_vec(1'b1, 64'd11, 6'd4, 2'd1, 1'b0)); end
        #2;
        rst_n = 1'b0;
        #1;
        o = out_vec();
        n_cmp++; if (o !== 74'd0) begin n_err++; $display("FAIL async_reset_outputs: got %h want 0", o); end
        n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL async_reset_s_tready: got %b want 1", bus.s_axis_tready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.m_axis_tready     = 1'b1;
        bus.s_axis_tvalid     = 1'b1;
        bus.s_axis_tkeep      = 4'b0001;
        bus.s_axis_tagtime[0] = 64'd77;
        bus.s_axis_channel[0] = 6'd3;
        @(negedge clk);
        idle_inputs();
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd77, 6'd3, 2'd0, 1'b1)) begin n_err++; $display("FAIL post_reset_beat: got %h want %h", o, exp_vec(1'b1, 64'd77, 6'd3, 2'd0, 1'b1)); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_drain: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (tag_count !== 32'd1) begin n_err++; $display("FAIL post_reset_count: got %0d want 1", tag_count); end
    endtask

    task automatic test_sparse_beat();
        logic [73:0] o;
        logic [31:0] base;
        logic [73:0] want [3];
        want[0] = exp_vec(1'b1, 64'd10, 6'd1, 2'd0, 1'b0);
        want[1] = exp_vec(1'b1, 64'd20, 6'd5, 2'd1, 1'b0);
        want[2] = exp_vec(1'b1, 64'd40, -6'sd2, 2'd3, 1'b1);
        @(negedge clk);
        base = tag_count;
        bus.m_axis_tready  = 1'b1;
        bus.s_axis_tvalid  = 1'b1;
        bus.s_axis_tkeep   = 4'b1011;
        bus.s_axis_tagtime = {64'd40, 64'd30, 64'd20, 64'd10};
        bus.s_axis_channel = {-6'sd2, 6'd9, 6'd5, 6'd1};
        #1;
        n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL sparse_accept: got %b want 1", bus.s_axis_tready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            o = out_vec();
            n_cmp++; if (o !== want[i]) begin n_err++; $display("FAIL sparse_tag%0d: got %h want %h", i, o, want[i]); end
            n_cmp++; if (bus.s_axis_tready !== (i == 2)) begin n_err++; $display("FAIL sparse_s_tready%0d: got %b want %b", i, bus.s_axis_tready, i == 2); end
        end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL sparse_drained: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (tag_count !== base + 32'd3) begin n_err++; $display("FAIL sparse_count: got %0d want %0d", tag_count, base + 32'd3); end
    endtask

    task automatic test_back_to_back();
        logic [73:0] o;
        logic [31:0] base;
        @(negedge clk);
        base = tag_count;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                #1;
                o = out_vec();
                n_cmp++; if (o !== exp_vec(1'b1, 64'(100 + i - 1), 6'(i), 2'd0, 1'b1)) begin n_err++; $display("FAIL b2b_tag%0d: got %h want %h", i - 1, o, exp_vec(1'b1, 64'(100 + i - 1), 6'(i), 2'd0, 1'b1)); end
                n_cmp++; if (tag_count !== base + 32'(i - 1)) begin n_err++; $display("FAIL b2b_count%0d: got %0d want %0d", i - 1, tag_count, base + 32'(i - 1)); end
            end
            if (i < 4) begin
                bus.s_axis_tvalid     = 1'b1;
                bus.s_axis_tkeep      = 4'b0001;
                bus.s_axis_tagtime[0] = 64'(100 + i);
                bus.s_axis_channel[0] = 6'(i + 1);
                #1;
                n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL b2b_s_tready%0d: got %b want 1", i, bus.s_axis_tready); end
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (tag_count !== base + 32'd4) begin n_err++; $display("FAIL b2b_final_count: got %0d want %0d", tag_count, base + 32'd4); end
    endtask

    task automatic test_zero_mask();
        logic [73:0] o;
        logic [31:0] base;
        @(negedge clk);
        base = tag_count;
        bus.m_axis_tready     = 1'b1;
        bus.s_axis_tvalid     = 1'b1;
        bus.s_axis_tkeep      = 4'b0001;
        bus.s_axis_tagtime[0] = 64'd200;
        bus.s_axis_channel[0] = 6'd2;
        @(negedge clk);
        bus.s_axis_tkeep      = 4'b0000;
        bus.s_axis_tagtime[0] = 64'd999;
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd200, 6'd2, 2'd0, 1'b1)) begin n_err++; $display("FAIL zm_first: got %h want %h", o, exp_vec(1'b1, 64'd200, 6'd2, 2'd0, 1'b1)); end
        n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL zm_accept_empty: got %b want 1", bus.s_axis_tready); end
        @(negedge clk);
        bus.s_axis_tkeep      = 4'b0010;
        bus.s_axis_tagtime[1] = 64'd210;
        bus.s_axis_channel[1] = -6'sd3;
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL zm_no_output: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (bus.s_axis_tready !== 1'b1) begin n_err++; $display("FAIL zm_next_accept: got %b want 1", bus.s_axis_tready); end
        @(negedge clk);
        idle_inputs();
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd210, -6'sd3, 2'd1, 1'b1)) begin n_err++; $display("FAIL zm_second: got %h want %h", o, exp_vec(1'b1, 64'd210, -6'sd3, 2'd1, 1'b1)); end
        @(negedge clk);
        #1;
        n_cmp++; if (tag_count !== base + 32'd2) begin n_err++; $display("FAIL zm_count: got %0d want %0d", tag_count, base + 32'd2); end
    endtask

    task automatic test_backpressure();
        logic [73:0] o;
        logic [73:0] prev;
        logic [73:0] want;
        logic        stalled;
        logic [31:0] base;
        int          nb;
        int          idx;
        nb      = 0;
        idx     = 0;
        stalled = 1'b0;
        prev    = '0;
        @(negedge clk);
        base = tag_count;
        for (int cyc = 0; cyc < 300 && idx < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.m_axis_tready = 1'($urandom_range(0, 1));
            if (nb < 3) begin
                bus.s_axis_tvalid = 1'b1;
                bus.s_axis_tkeep  = 4'hF;
                for (int l = 0; l < 4; l++) begin
                    bus.s_axis_tagtime[l] = 64'(1000 + nb * 10 + l);
                    bus.s_axis_channel[l] = 6'(l + 1 + nb);
                end
            end else begin
                idle_inputs();
            end
            #1;
            o = out_vec();
            if (stalled) begin
                n_cmp++; if (o !== prev) begin n_err++; $display("FAIL bp_stable: got %h want %h", o, prev); end
            end
            if (bus.m_axis_tvalid) begin
                want = exp_vec(1'b1, 64'(1000 + (idx / 4) * 10 + idx % 4), 6'((idx % 4) + 1 + idx / 4),
                               2'(idx % 4), (idx % 4) == 3);
                n_cmp++; if (o !== want) begin n_err++; $display("FAIL bp_order%0d: got %h want %h", idx, o, want); end
            end
            stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev    = o;
            if (bus.m_axis_tvalid && bus.m_axis_tready) idx++;
            if (bus.s_axis_tvalid && bus.s_axis_tready) nb++;
        end
        n_cmp++; if (idx !== 12) begin n_err++; $display("FAIL bp_timeout: got %0d tags want 12", idx); end
        @(negedge clk);
        idle_inputs();
        bus.m_axis_tready = 1'b1;
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_extra_tag: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (tag_count !== base + 32'd12) begin n_err++; $display("FAIL bp_count: got %0d want %0d", tag_count, base + 32'd12); end
    endtask

`ifdef SI_TAG_SERIALIZER_FILTER_EN
    task automatic test_filter();
        logic [73:0] o;
        logic [31:0] base;
        @(negedge clk);
        base              = tag_count;
        channel_enable    = 40'd1;
        bus.m_axis_tready  = 1'b1;
        bus.s_axis_tvalid  = 1'b1;
        bus.s_axis_tkeep   = 4'hF;
        bus.s_axis_tagtime = {64'd304, 64'd303, 64'd302, 64'd301};
        bus.s_axis_channel = {6'd1, -6'sd1, 6'd3, 6'd1};
        @(negedge clk);
        idle_inputs();
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd301, 6'd1, 2'd0, 1'b0)) begin n_err++; $display("FAIL filt_lane0: got %h want %h", o, exp_vec(1'b1, 64'd301, 6'd1, 2'd0, 1'b0)); end
        @(negedge clk);
        #1;
        o = out_vec();
        n_cmp++; if (o !== exp_vec(1'b1, 64'd304, 6'd1, 2'd3, 1'b1)) begin n_err++; $display("FAIL filt_lane3: got %h want %h", o, exp_vec(1'b1, 64'd304, 6'd1, 2'd3, 1'b1)); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus.m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL filt_drained: got %b want 0", bus.m_axis_tvalid); end
        n_cmp++; if (tag_count !== base + 32'd2) begin n_err++; $display("FAIL filt_count: got %0d want %0d", tag_count, base + 32'd2); end
        channel_enable = '1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.m_axis_tready = 1'b0;
        idle_inputs();
`ifdef SI_TAG_SERIALIZER_FILTER_EN
        channel_enable = '1;
`endif
        test_reset();
        test_sparse_beat();
        test_back_to_back();
        test_zero_mask();
        test_backpressure();
`ifdef SI_TAG_SERIALIZER_FILTER_EN
        test_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
